tile_stream_sf_buffer: RTL
==========================

Name: tile_stream_sf_buffer

Overview:
- Parametrised successor of the 4-lane FFT tile stream front end: NCH independent AXI-stream lanes, each with a DEPTH-word FIFO.
- Output release is gated by the tile start pulse. Each lane runs in cut-through or store-and-forward mode.
- Sits between the NoC stream ports and the tile compute core, in the clk_line domain.

Parameters:
- NCH, 4, number of stream lanes.
- BW, 32, TDATA width per lane in bits.
- BWB, BW/8, TKEEP width per lane.
- DEPTH, 16, FIFO words per lane; power of two, >=2.
- CNT_W, 16, per-lane frame counter width.

Ports:
- clk_line  in  1  single clock.
- clk_line_rst_low  in  1  reset, asynchronous, active-low.
- plain_start_of_processing  in  1  one-cycle arm pulse.
- mode_sf  in  NCH  per lane: 1=store-and-forward, 0=cut-through; sampled every cycle.
- stream_in_TVALID  in  NCH
- stream_in_TDATA  in  NCH*BW
- stream_in_TKEEP  in  NCH*BWB
- stream_in_TLAST  in  NCH
- stream_in_TREADY  out  NCH
- stream_out_TVALID  out  NCH
- stream_out_TDATA  out  NCH*BW
- stream_out_TKEEP  out  NCH*BWB
- stream_out_TLAST  out  NCH
- stream_out_TREADY  in  NCH
- armed  out  1  sticky arm status.
- frame_count  out  NCH*CNT_W  frames emitted per lane.

Behaviour:
- Reset (async assert, sync deassert in the clk_line domain): FIFOs empty; armed=0; TVALID=0; TREADY=0 during reset and 1 on the first cycle after; frame_count=0; pending=0; flush=0.
- Lane slicing: lane i uses bits [i*BW +: BW], and likewise for TKEEP and frame_count.
- Push: stream_in_TREADY[i] = !full[i], combinational from registered occupancy. A push happens when TVALID&&TREADY; {TDATA,TKEEP,TLAST} are stored.
- Pop: stream_out_TVALID&&stream_out_TREADY.
- Simultaneous push and pop: occupancy unchanged. When full, TREADY=0, so no push occurs even if a pop happens the same cycle.
- Occupancy counter runs 0..DEPTH; full = (occ==DEPTH). Pointers wrap modulo DEPTH.
- Arm: armed is set on plain_start_of_processing and stays set until reset. Inputs are accepted while unarmed; outputs are held at TVALID=0.
- pending[i] (0..DEPTH):
  - +1 on a push with TLAST=1.
  - -1 on a pop with TLAST=1.
  - Both in the same cycle: unchanged.
- flush[i]:
  - Set when the lane is full, mode_sf=1 and pending==0 (oversize frame; prevents deadlock).
  - Cleared on a pop with TLAST=1.
- Release condition: stream_out_TVALID[i] = armed && !empty && (!mode_sf[i] || pending>0 || flush).
- Output data comes from the FIFO head, with no skid register.
- Latency: a word pushed at edge t is visible with TVALID at t+1 in cut-through mode, or at t+1 after its frame's TLAST push in store-and-forward mode.
- AXI rule: once TVALID is high it holds, with data stable, until accepted. A mode_sf change can therefore only raise TVALID, never drop it mid-word. Drop is prevented by latching a per-lane "offered" bit, set when TVALID rises and cleared on pop.
- frame_count[i]: +1 on each pop with TLAST=1; wraps at 2^CNT_W-1 -> 0.
- TKEEP is passed unmodified and does not affect control.
- Reset asserted mid-frame discards all buffered data immediately.

Optional Feature:
- Macro TILE_STREAM_FRAME_CNT_EN.
- Defined: frame_count logic as described above.
- Undefined: counters are not instantiated and frame_count is tied to 0. All other behaviour is identical.

Test Plan:
- Reset, unarmed, lane0 pushes 3 words 0xA0..0xA2 (last TLAST) -> TVALID0=0, occ=3, TREADY0=1. After the arm pulse: TVALID0=1 next cycle; words pop in order; frame_count[0]=1.
- Armed, lane1 mode_sf=0, push 0x11 at edge t -> TVALID1=1 at t+1 with TDATA=0x11.
- Armed, lane2 mode_sf=1, push 4 words with TLAST on the 4th -> TVALID2 stays 0 until the cycle after the 4th push, then streams 4 words back-to-back with TREADY=1.
- DEPTH=16, mode_sf=1, 20-word frame with stream_out_TREADY=1:
  - TREADY drops at occ=16 and flush sets.
  - All 20 words exit in order with a single TLAST.
  - flush clears and frame_count increments by 1.
- Full lane with concurrent push attempt and pop -> no push accepted that cycle; occ goes 16->15; TREADY=1 next cycle.
- Assert reset while 5 words are buffered on all lanes -> all TVALID=0 and frame_count=0 immediately (asynchronous); armed=0 after release.

Source files
------------

// File: rtl/tile_stream_sf_buffer.sv
// NCH-lane AXI-stream tile front end: per-lane DEPTH-word FIFO with cut-through or
// store-and-forward release, gated by a sticky arm. Define TILE_STREAM_FRAME_CNT_EN for per-lane frame counters.
module tile_stream_sf_buffer #(
    parameter int NCH   = 4,
    parameter int BW    = 32,
    parameter int BWB   = BW / 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                 clk_line,
    input  logic                 clk_line_rst_low,
    input  logic                 plain_start_of_processing,
    input  logic [NCH-1:0]       mode_sf,
    input  logic [NCH-1:0]       stream_in_TVALID,
    input  logic [NCH*BW-1:0]    stream_in_TDATA,
    input  logic [NCH*BWB-1:0]   stream_in_TKEEP,
    input  logic [NCH-1:0]       stream_in_TLAST,
    output logic [NCH-1:0]       stream_in_TREADY,
    output logic [NCH-1:0]       stream_out_TVALID,
    output logic [NCH*BW-1:0]    stream_out_TDATA,
    output logic [NCH*BWB-1:0]   stream_out_TKEEP,
    output logic [NCH-1:0]       stream_out_TLAST,
    input  logic [NCH-1:0]       stream_out_TREADY,
    output logic                 armed,
    output logic [NCH*CNT_W-1:0] frame_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [BW-1:0]  data;
        logic [BWB-1:0] keep;
        logic           last;
    } word_t;

    logic armed_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) armed_q <= 1'b0;
        else if (plain_start_of_processing) armed_q <= 1'b1;
    end

    assign armed = armed_q;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        word_t          mem [DEPTH];
        word_t          head;
        logic [AW-1:0]  wr_ptr, rd_ptr;
        logic [OW-1:0]  occ, pending;
        logic           flush, offered;
        logic           full, empty, push, pop, push_last, pop_last, tvalid;

        assign full  = (occ == OW'(DEPTH));
        assign empty = (occ == '0);
        assign head  = mem[rd_ptr];

        // Ready is held low while reset is asserted; occupancy alone would read empty.
        assign stream_in_TREADY[i] = clk_line_rst_low & ~full;
        assign push      = stream_in_TVALID[i] & stream_in_TREADY[i];
        assign push_last = push & stream_in_TLAST[i];

        // Once offered, a word stays valid even if mode_sf flips to store-and-forward.
        assign tvalid    = armed_q & ~empty & (offered | ~mode_sf[i] | (pending != '0) | flush);
        assign pop       = tvalid & stream_out_TREADY[i];
        assign pop_last  = pop & head.last;

        // NOTE: storage has no reset; occupancy and pointers define what is valid.
        always_ff @(posedge clk_line) begin
            if (push) mem[wr_ptr] <= '{data: stream_in_TDATA[i*BW +: BW],
                                       keep: stream_in_TKEEP[i*BWB +: BWB],
                                       last: stream_in_TLAST[i]};
        end

        always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
            if (!clk_line_rst_low) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                occ     <= '0;
                pending <= '0;
                flush   <= 1'b0;
                offered <= 1'b0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   occ <= occ + OW'(1);
                    2'b01:   occ <= occ - OW'(1);
                    default: occ <= occ;
                endcase
                case ({push_last, pop_last})
                    2'b10:   pending <= pending + OW'(1);
                    2'b01:   pending <= pending - OW'(1);
                    default: pending <= pending;
                endcase
                // A frame larger than the FIFO can never complete, so release it early.
                if (pop_last) flush <= 1'b0;
                else if (full && mode_sf[i] && pending == '0) flush <= 1'b1;
                offered <= tvalid & ~pop;
            end
        end

        assign stream_out_TVALID[i]          = tvalid;
        assign stream_out_TDATA[i*BW +: BW]  = head.data;
        assign stream_out_TKEEP[i*BWB +: BWB] = head.keep;
        assign stream_out_TLAST[i]           = head.last;

`ifdef TILE_STREAM_FRAME_CNT_EN
        logic [CNT_W-1:0] fcnt;

        always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
            if (!clk_line_rst_low) fcnt <= '0;
            else if (pop_last) fcnt <= fcnt + CNT_W'(1);
        end

        assign frame_count[i*CNT_W +: CNT_W] = fcnt;
`else
        assign frame_count[i*CNT_W +: CNT_W] = '0;
`endif
    end

endmodule
